// File: rtl/fb_scanout.sv
// fb_scanout: streams the 1bpp framebuffer as a valid/ready pixel stream, MSB first, with one-byte prefetch
module fb_scanout #(
  parameter logic [11:0] FB_OFFSET = 12'h100,
  parameter int FB_WIDTH = 64,
  parameter int FB_HEIGHT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic        scan_mem_read,
  output logic [11:0] scan_mem_read_addr,
  input  logic [7:0]  scan_mem_read_data,
  input  logic        scan_mem_read_ack,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic        pix_sof,
  output logic        pix_eol
);
  localparam int BYTES = FB_WIDTH * FB_HEIGHT / 8;
  localparam int IW = $clog2(BYTES + 1);
  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT + 1);
  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] fetch_idx, fetch_idx_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift_reg, shift_n, next_byte, next_byte_n;
  logic next_valid, next_valid_n, read_n;
  logic [11:0] addr_n;
  logic ack, hs, more, last_x, stream_n;
  assign ack = scan_mem_read & scan_mem_read_ack;
  assign hs = pix_valid & pix_ready;
  assign more = fetch_idx < IW'(BYTES);
  assign last_x = x == XW'(FB_WIDTH - 1);
  assign stream_n = state_n == STREAM;
  always_comb begin
    state_n = state;
    fetch_idx_n = fetch_idx;
    x_n = x;
    y_n = y;
    bit_cnt_n = bit_cnt;
    shift_n = shift_reg;
    next_byte_n = next_byte;
    next_valid_n = next_valid;
    read_n = scan_mem_read;
    addr_n = scan_mem_read_addr;
    case (state)
      IDLE: if (frame_start) begin
        state_n = FETCH;
        fetch_idx_n = '0;
        x_n = '0;
        y_n = '0;
        bit_cnt_n = '0;
        next_valid_n = 1'b0;
        read_n = 1'b1;
        addr_n = FB_OFFSET;
      end
      FETCH: if (ack) begin
        shift_n = scan_mem_read_data;
        bit_cnt_n = '0;
        fetch_idx_n = fetch_idx + 1'b1;
        read_n = 1'b0;
        state_n = STREAM;
      end else if (!scan_mem_read) begin
        read_n = 1'b1;
        addr_n = FB_OFFSET + 12'(fetch_idx);
      end
      STREAM: begin
        if (ack) begin
          read_n = 1'b0;
          fetch_idx_n = fetch_idx + 1'b1;
          next_byte_n = scan_mem_read_data;
          next_valid_n = 1'b1;
        end else if (!next_valid && !scan_mem_read && more) begin
          read_n = 1'b1;
          addr_n = FB_OFFSET + 12'(fetch_idx);
        end
        if (hs) begin
          shift_n = {shift_reg[6:0], 1'b0};
          bit_cnt_n = bit_cnt + 3'd1;
          x_n = last_x ? '0 : x + 1'b1;
          y_n = last_x ? y + 1'b1 : y;
          // Byte boundary: a read landing on this very edge bypasses next_byte
          if (bit_cnt == 3'd7) begin
            if (next_valid) begin
              shift_n = next_byte;
              next_valid_n = 1'b0;
            end else if (ack) begin
              shift_n = scan_mem_read_data;
              next_valid_n = 1'b0;
            end else begin
              state_n = more ? FETCH : DONE;
            end
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fetch_idx <= '0;
      x <= '0;
      y <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      next_byte <= '0;
      next_valid <= 1'b0;
      scan_mem_read <= 1'b0;
      scan_mem_read_addr <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      pix_valid <= 1'b0;
      pix_data <= 1'b0;
      pix_sof <= 1'b0;
      pix_eol <= 1'b0;
    end else begin
      state <= state_n;
      fetch_idx <= fetch_idx_n;
      x <= x_n;
      y <= y_n;
      bit_cnt <= bit_cnt_n;
      shift_reg <= shift_n;
      next_byte <= next_byte_n;
      next_valid <= next_valid_n;
      scan_mem_read <= read_n;
      scan_mem_read_addr <= addr_n;
      busy <= state_n != IDLE;
      frame_done <= state_n == DONE;
      pix_valid <= stream_n;
      pix_data <= stream_n & shift_n[7];
      pix_sof <= stream_n && x_n == '0 && y_n == '0;
      pix_eol <= stream_n && x_n == XW'(FB_WIDTH - 1);
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: randomized scanout checks against a pixel-order reference model of the framebuffer
module tb_fb_scanout;
  localparam int W = 64;
  localparam int H = 32;
  localparam int NPIX = W * H;
  localparam int NBYTES = NPIX / 8;
  logic clk = 0, rst = 1, frame_start = 0, scan_mem_read_ack = 0, pix_ready = 0;
  logic [7:0] scan_mem_read_data = 0;
  logic busy, frame_done, scan_mem_read, pix_valid, pix_data, pix_sof, pix_eol;
  logic [11:0] scan_mem_read_addr;
  fb_scanout dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .scan_mem_read(scan_mem_read), .scan_mem_read_addr(scan_mem_read_addr),
    .scan_mem_read_data(scan_mem_read_data), .scan_mem_read_ack(scan_mem_read_ack),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [4096];
  int lat_fixed = 1;
  bit lat_rand = 0, rand_ready = 0;
  logic ready_fix = 1;
  int assertions = 0, failures = 0;
  bit got_q [$];
  bit sof_q [$];
  bit eol_q [$];
  logic [11:0] addr_q [$];
  int gaps, stab_err, done_cnt, coincide;
  bit pending;
  int wcnt;
  // memory responder and ready driver, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    if (rst) begin
      scan_mem_read_ack = 0;
      pending = 0;
    end else if (scan_mem_read_ack) begin
      scan_mem_read_ack = 0;
      pending = 0;
    end else if (scan_mem_read) begin
      if (!pending) begin
        pending = 1;
        wcnt = lat_rand ? int'($urandom_range(0, 5)) : lat_fixed;
        addr_q.push_back(scan_mem_read_addr);
      end
      if (wcnt == 0) begin
        scan_mem_read_ack = 1;
        scan_mem_read_data = mem[scan_mem_read_addr];
      end else wcnt--;
    end
  end
  bit prev_stall;
  logic prev_data;
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall && (pix_valid !== 1'b1 || pix_data !== prev_data)) stab_err++;
      if (pix_valid && pix_ready) begin
        if (scan_mem_read && scan_mem_read_ack && got_q.size() % 8 == 7) coincide++;
        got_q.push_back(pix_data);
        sof_q.push_back(pix_sof);
        eol_q.push_back(pix_eol);
      end else if (busy && !pix_valid && got_q.size() > 0 && got_q.size() < NPIX) gaps++;
      if (frame_done) done_cnt++;
      prev_stall = pix_valid && !pix_ready;
      prev_data = pix_data;
    end
  end
  function automatic int stream_errors();
    int e = (got_q.size() != NPIX) ? 1 : 0;
    for (int k = 0; k < got_q.size() && k < NPIX; k++) begin
      int row = k / W;
      int col = k % W;
      logic [7:0] b = mem[12'(256 + row * (W / 8) + col / 8)];
      if (got_q[k] !== b[7 - col % 8]) e++;
      if (sof_q[k] !== (k == 0)) e++;
      if (eol_q[k] !== (col == W - 1)) e++;
    end
    return e;
  endfunction
  function automatic int addr_errors();
    int e = (addr_q.size() != NBYTES) ? 1 : 0;
    for (int k = 0; k < addr_q.size(); k++) if (addr_q[k] !== 12'(256 + k)) e++;
    return e;
  endfunction
  task automatic clear_log();
    got_q.delete();
    sof_q.delete();
    eol_q.delete();
    addr_q.delete();
    gaps = 0;
    stab_err = 0;
    done_cnt = 0;
    coincide = 0;
  endtask
  task automatic start_frame();
    @(posedge clk);
    #1 frame_start = 1;
    @(posedge clk);
    #1 frame_start = 0;
  endtask
  task automatic wait_done(output bit to);
    for (int c = 0; c < 20000 && done_cnt == 0; c++) @(posedge clk);
    to = done_cnt == 0;
    repeat (20) @(posedge clk);
    #1;
  endtask
  task automatic set_mode(input bit rl, input int lf, input bit rr);
    lat_rand = rl;
    lat_fixed = lf;
    rand_ready = rr;
    ready_fix = 1;
  endtask
  task automatic test_reset();
    logic [18:0] outs;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 outs = {busy, frame_done, scan_mem_read, scan_mem_read_addr, pix_valid, pix_data, pix_sof, pix_eol};
    assertions++;
    if (outs !== 19'd0) begin failures++; $display("FAIL reset_outputs got %h want 0", outs); end
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
    assertions++;
    if ({busy, scan_mem_read, pix_valid} !== 3'b000) begin
      failures++; $display("FAIL idle_quiet got %b want 000", {busy, scan_mem_read, pix_valid});
    end
  endtask
  task automatic test_alternating();
    bit to;
    int sofs = 0, eols = 0, alt_bad = 0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    for (int a = 256; a < 512; a++) mem[a] = 8'hAA;
    set_mode(0, 1, 0);
    clear_log();
    start_frame();
    wait_done(to);
    for (int k = 0; k < got_q.size(); k++) begin
      sofs += sof_q[k];
      eols += eol_q[k];
      if (got_q[k] !== (k % 2 == 0)) alt_bad++;
    end
    assertions++;
    if (to !== 1'b0) begin failures++; $display("FAIL alt_timeout frame_done never seen"); end
    assertions++;
    if (got_q.size() !== NPIX) begin failures++; $display("FAIL alt_count got %0d want %0d", got_q.size(), NPIX); end
    assertions++;
    if (alt_bad !== 0) begin failures++; $display("FAIL alt_pattern got %0d bad pixels want 0", alt_bad); end
    assertions++;
    if (stream_errors() !== 0) begin failures++; $display("FAIL alt_model got %0d errors want 0", stream_errors()); end
    assertions++;
    if (gaps !== 0) begin failures++; $display("FAIL alt_gaps got %0d want 0", gaps); end
    assertions++;
    if (sofs !== 1 || sof_q[0] !== 1'b1) begin failures++; $display("FAIL alt_sof got %0d want 1 on pixel 0", sofs); end
    assertions++;
    if (eols !== H) begin failures++; $display("FAIL alt_eol got %0d want %0d", eols, H); end
    assertions++;
    if (done_cnt !== 1) begin failures++; $display("FAIL alt_done got %0d want 1", done_cnt); end
    assertions++;
    if (busy !== 1'b0) begin failures++; $display("FAIL alt_idle busy got %b want 0", busy); end
  endtask
  task automatic test_corners();
    bit to;
    int ones = 0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h0FF] = 8'hFF;
    mem[12'h200] = 8'hFF;
    mem[12'h100] = 8'h80;
    mem[12'h1FF] = 8'h01;
    set_mode(0, 1, 0);
    clear_log();
    start_frame();
    wait_done(to);
    foreach (got_q[k]) ones += got_q[k];
    assertions++;
    if (to !== 1'b0) begin failures++; $display("FAIL corner_timeout frame_done never seen"); end
    assertions++;
    if (ones !== 2 || got_q[0] !== 1'b1 || got_q[NPIX-1] !== 1'b1) begin
      failures++; $display("FAIL corner_pixels got %0d ones (p0=%b p2047=%b) want 2 at ends", ones, got_q[0], got_q[NPIX-1]);
    end
    assertions++;
    if (addr_errors() !== 0) begin
      failures++; $display("FAIL corner_addrs got %0d reads with %0d errors want 256 in order", addr_q.size(), addr_errors());
    end
    assertions++;
    if (stream_errors() !== 0) begin failures++; $display("FAIL corner_model got %0d errors want 0", stream_errors()); end
  endtask
  task automatic test_random();
    bit to;
    for (int r = 0; r < 2; r++) begin
      for (int a = 256; a < 512; a++) mem[a] = 8'($urandom);
      set_mode(1, 0, 1);
      clear_log();
      start_frame();
      wait_done(to);
      assertions++;
      if (to !== 1'b0) begin failures++; $display("FAIL rand_timeout round %0d", r); end
      assertions++;
      if (stream_errors() !== 0) begin
        failures++; $display("FAIL rand_model round %0d got %0d errors (%0d pixels) want 0", r, stream_errors(), got_q.size());
      end
      assertions++;
      if (stab_err !== 0) begin failures++; $display("FAIL rand_stable round %0d got %0d changes want 0", r, stab_err); end
      assertions++;
      if (addr_errors() !== 0) begin failures++; $display("FAIL rand_addrs round %0d got %0d errors want 0", r, addr_errors()); end
      assertions++;
      if (done_cnt !== 1) begin failures++; $display("FAIL rand_done round %0d got %0d want 1", r, done_cnt); end
    end
  endtask
  task automatic test_ack_last_bit();
    bit to;
    for (int a = 256; a < 512; a++) mem[a] = 8'($urandom);
    set_mode(0, 6, 0);
    clear_log();
    start_frame();
    wait_done(to);
    assertions++;
    if (to !== 1'b0) begin failures++; $display("FAIL lastbit_timeout frame_done never seen"); end
    assertions++;
    if (coincide < 100) begin failures++; $display("FAIL lastbit_coincide got %0d want >= 100", coincide); end
    assertions++;
    if (stream_errors() !== 0) begin
      failures++; $display("FAIL lastbit_model got %0d errors (%0d pixels) want 0", stream_errors(), got_q.size());
    end
    assertions++;
    if (gaps !== 0) begin failures++; $display("FAIL lastbit_gaps got %0d want 0", gaps); end
  endtask
  task automatic test_mid_reset();
    bit to;
    logic [18:0] outs;
    for (int a = 256; a < 512; a++) mem[a] = 8'($urandom);
    set_mode(0, 1, 0);
    clear_log();
    start_frame();
    for (int c = 0; c < 5000 && got_q.size() < 300; c++) @(negedge clk);
    assertions++;
    if (got_q.size() < 300) begin failures++; $display("FAIL midrst_progress got %0d pixels want 300", got_q.size()); end
    #2 rst = 1;
    #1 outs = {busy, frame_done, scan_mem_read, scan_mem_read_addr, pix_valid, pix_data, pix_sof, pix_eol};
    assertions++;
    if (outs !== 19'd0) begin failures++; $display("FAIL midrst_outputs got %h want 0", outs); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_log();
    start_frame();
    wait_done(to);
    assertions++;
    if (to !== 1'b0) begin failures++; $display("FAIL midrst_timeout frame_done never seen"); end
    assertions++;
    if (addr_q.size() == 0 || addr_q[0] !== 12'h100) begin failures++; $display("FAIL midrst_first_addr got %h want 100", addr_q[0]); end
    assertions++;
    if (sof_q.size() == 0 || sof_q[0] !== 1'b1) begin failures++; $display("FAIL midrst_sof got %b want 1", sof_q[0]); end
    assertions++;
    if (stream_errors() !== 0) begin failures++; $display("FAIL midrst_model got %0d errors want 0", stream_errors()); end
  endtask
  task automatic test_start_while_busy();
    bit to;
    for (int a = 256; a < 512; a++) mem[a] = 8'($urandom);
    set_mode(1, 0, 0);
    clear_log();
    start_frame();
    for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
      @(posedge clk);
      #1 frame_start = busy && (c % 37 == 5);
    end
    frame_start = 0;
    to = done_cnt == 0;
    repeat (200) @(posedge clk);
    #1;
    assertions++;
    if (to !== 1'b0) begin failures++; $display("FAIL busy_timeout frame_done never seen"); end
    assertions++;
    if (done_cnt !== 1) begin failures++; $display("FAIL busy_done got %0d want 1", done_cnt); end
    assertions++;
    if (addr_errors() !== 0) begin failures++; $display("FAIL busy_addrs got %0d reads, %0d errors want 256 in order", addr_q.size(), addr_errors()); end
    assertions++;
    if (stream_errors() !== 0) begin failures++; $display("FAIL busy_model got %0d errors want 0", stream_errors()); end
    assertions++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle got %b want 0", busy); end
  endtask
  initial begin
    test_reset();
    test_alternating();
    test_corners();
    test_random();
    test_ack_last_bit();
    test_mid_reset();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
